proj_kmer_buffer: RTL and testbench
===================================

# proj_kmer_buffer

Streaming k-mer extractor that sits directly upstream of `proj_hasher`. It accepts one 2-bit-encoded base per cycle and keeps a sliding window of the last `KMER_LEN` bases. For every full window it emits one registered k-mer word, `KMER_LEN*BASE_BITS` bits wide, which drives the hasher's `kmer` input. Throughput is one k-mer per cycle under valid/ready flow control.

## Interface
- `KMER_LEN`, default `proj_pkg::KMER_BUFFER_HASHER_KMER_LEN` (16): bases per k-mer; must be ≥ 2.
- `BASE_BITS`, default `proj_pkg::KMER_BUFFER_HASHER_BASE_BITS` (2): bits per base. Encoding is A=00, C=01, G=10, T=11.
- `HASHER_DATA_BITS`, default `KMER_LEN*BASE_BITS`: output k-mer width.
- `POS_BITS`, default 16: width of the position counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `in_valid` in 1: a base is present.
- `in_ready` out 1: the block can accept a base.
- `in_base` in BASE_BITS: base value.
- `in_seq_start` in 1: qualified by `in_valid`; this base is the first base of a new sequence.
- `out_valid` out 1: the k-mer output is valid.
- `out_ready` in 1: the consumer accepts the k-mer.
- `out_kmer` out HASHER_DATA_BITS: k-mer. Oldest base is at the MSBs, newest base at the LSBs.
- `out_pos` out POS_BITS: index, within the current sequence, of the k-mer's first base.

## Operation
- An input handshake occurs when `in_valid && in_ready`.
- `in_ready = !rst && (!out_valid || out_ready)`. This is combinational; there is no skid buffer.
- On each input handshake:
  - Window update: `win <= {win[HASHER_DATA_BITS-BASE_BITS-1:0], in_base}`.
  - Fill counter `fill`, range 0..KMER_LEN: `fill <= min(fill+1, KMER_LEN)`.
  - If `in_seq_start`: `fill <= 1`, the window still shifts, and the position counter `pos` clears to 0. Stale bases left in the window are masked by `fill`.
- k-mer emission: when the handshake leaves `fill == KMER_LEN`, the k-mer is loaded into the output register.
  - `out_valid <= 1`.
  - `out_kmer` is the new window.
  - `out_pos <= pos`.
  - `pos` then increments by one once per emitted k-mer. It wraps modulo 2^POS_BITS with no flag.
- Output register behaviour:
  - It holds its value while `out_valid && !out_ready`.
  - It clears `out_valid` on `out_ready` unless a new k-mer loads in the same cycle. Load takes priority, so there are no bubbles.
- `in_seq_start` with `fill < KMER_LEN` from the previous sequence: the partial k-mer is discarded silently.
- An `out_valid` k-mer already pending is unaffected by `in_seq_start`; it drains normally.
- States are implicit in `fill`:
  - FILLING: `fill < KMER_LEN`. No emission.
  - STREAMING: `fill == KMER_LEN`. Every accepted base emits a k-mer.

## Timing
- Reset values (every output and all state):
  - `out_valid=0`, `out_kmer=0`, `out_pos=0`.
  - `win=0`, `fill=0`, `pos=0`.
  - `in_ready=0` while `rst` is high and 1 in the first cycle after reset.
- Latency: `out_valid` rises 1 cycle after the handshake of the `KMER_LEN`-th base of a sequence.
- Steady state: 1 k-mer per cycle with `out_ready` held high.
- Backpressure: while `out_valid && !out_ready`, `in_ready=0`, and `out_kmer` and `out_pos` are stable.
- Reset mid-operation: `rst` has priority over everything. A pending k-mer is dropped, and `fill` returns to 0.

## Configuration
- `PROJ_KMER_BUFFER_CANONICAL_EN` defined:
  - A reverse-complement window is kept in parallel: `rc <= {~in_base, rc[HASHER_DATA_BITS-1:BASE_BITS]}`. It is cleared with `win` on reset.
  - `out_kmer` is loaded with the unsigned minimum of `win` and `rc`, i.e. the canonical k-mer.
  - Latency is unchanged; the comparison is done before the output register.
- Not defined: `out_kmer` is the forward window, and no `rc` logic is synthesized.

## Test plan
(Vectors use KMER_LEN=16, BASE_BITS=2.)
- Fill: reset, then 16 bases of C (01) with `in_seq_start` on the first and `out_ready=1` → exactly one k-mer, `out_kmer=32'h55555555`, `out_pos=0`, 1 cycle after the 16th base; `out_valid=0` before it.
- Slide: 17 bases of repeating A,C,G,T → k-mers `32'h1B1B1B1B` at pos 0 and `32'h6C6C6C6C` at pos 1, on consecutive cycles.
- Backpressure: hold `out_ready=0` for 5 cycles while `out_valid=1` → `in_ready=0`, and `out_kmer`/`out_pos` are unchanged. Release → the stream resumes with no lost or duplicated k-mers.
- New sequence: assert `in_seq_start` on the 20th base → no k-mer until 15 more bases are accepted; the next k-mer has `out_pos=0`.
- Reset: assert `rst` while `out_valid=1` → the next cycle has `out_valid=0`, and 16 further bases are needed before the next emission.
- Canonical (macro defined): 16 bases of T → `out_kmer=32'h00000000`. Repeating C,G,T,A for 16 bases → `32'h6C6C6C6C` (forward < rc `32'hC6C6C6C6`). Macro undefined, 16 bases of T → `32'hFFFFFFFF`.

Source files
------------

// File: rtl/proj_kmer_buffer.sv
// Streaming k-mer extractor feeding proj_hasher: slides a KMER_LEN-base window and emits one k-mer per accepted base once full.
// Optional PROJ_KMER_BUFFER_CANONICAL_EN emits min(forward, reverse-complement) instead of the forward window.
package proj_pkg;
  localparam int KMER_BUFFER_HASHER_KMER_LEN  = 16;
  localparam int KMER_BUFFER_HASHER_BASE_BITS = 2;
endpackage

module proj_kmer_buffer #(
  parameter int KMER_LEN         = proj_pkg::KMER_BUFFER_HASHER_KMER_LEN,
  parameter int BASE_BITS        = proj_pkg::KMER_BUFFER_HASHER_BASE_BITS,
  parameter int HASHER_DATA_BITS = KMER_LEN * BASE_BITS,
  parameter int POS_BITS         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BASE_BITS-1:0]        in_base,
  input  logic                        in_seq_start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [HASHER_DATA_BITS-1:0] out_kmer,
  output logic [POS_BITS-1:0]         out_pos
);

  localparam int FILL_W = $clog2(KMER_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(KMER_LEN);

  logic [HASHER_DATA_BITS-1:0] win;
  logic [HASHER_DATA_BITS-1:0] win_nxt;
  logic [HASHER_DATA_BITS-1:0] kmer_nxt;
  logic [FILL_W-1:0]           fill;
  logic [FILL_W-1:0]           fill_nxt;
  logic [POS_BITS-1:0]         pos;
  logic                        in_hs;
  logic                        emit;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;

  // A sequence start restarts the fill count; stale window bases are masked by fill, not cleared.
  always_comb begin
    win_nxt = {win[HASHER_DATA_BITS-BASE_BITS-1:0], in_base};
    if (in_seq_start) begin
      fill_nxt = FILL_W'(1);
    end else if (fill == FILL_FULL) begin
      fill_nxt = fill;
    end else begin
      fill_nxt = fill + FILL_W'(1);
    end
  end

  assign emit = in_hs && (fill_nxt == FILL_FULL);

`ifdef PROJ_KMER_BUFFER_CANONICAL_EN
  function automatic logic [HASHER_DATA_BITS-1:0] canon_min(
    input logic [HASHER_DATA_BITS-1:0] fwd,
    input logic [HASHER_DATA_BITS-1:0] rev
  );
    return (fwd < rev) ? fwd : rev;
  endfunction

  logic [HASHER_DATA_BITS-1:0] rc;
  logic [HASHER_DATA_BITS-1:0] rc_nxt;

  // Reverse complement grows from the MSB end so it always mirrors win.
  assign rc_nxt   = {~in_base, rc[HASHER_DATA_BITS-1:BASE_BITS]};
  assign kmer_nxt = canon_min(win_nxt, rc_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      rc <= '0;
    end else if (in_hs) begin
      rc <= rc_nxt;
    end
  end
`else
  assign kmer_nxt = win_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      win       <= '0;
      fill      <= '0;
      pos       <= '0;
      out_valid <= 1'b0;
      out_kmer  <= '0;
      out_pos   <= '0;
    end else begin
      if (in_hs) begin
        win  <= win_nxt;
        fill <= fill_nxt;
        if (in_seq_start) begin
          pos <= '0;
        end else if (emit) begin
          pos <= pos + POS_BITS'(1);
        end
      end
      // Loading a new k-mer wins over draining so the stream has no bubbles.
      if (emit) begin
        out_valid <= 1'b1;
        out_kmer  <= kmer_nxt;
        out_pos   <= pos;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proj_kmer_buffer.sv
// Self-checking bench for proj_kmer_buffer (KMER_LEN=16, BASE_BITS=2): vector table plus scoreboard of expected k-mers.
// Honours PROJ_KMER_BUFFER_CANONICAL_EN to match the DUT build.
module tb_proj_kmer_buffer;

  localparam int KL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_base;
  logic        in_seq_start;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_kmer;
  logic [15:0] out_pos;

  proj_kmer_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_base      (in_base),
    .in_seq_start (in_seq_start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kmer     (out_kmer),
    .out_pos      (out_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] kmer;
    logic [15:0] pos;
  } exp_t;

  typedef struct {
    logic [7:0]  pat;
    int          nbases;
    logic [31:0] exp_kmer;
    int          exp_pos;
    int          exp_cnt;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          emit_count = 0;
  logic [31:0] last_kmer = '0;
  logic [15:0] last_pos  = '0;

  logic [1:0]  hist[KL];
  int          m_fill = 0;
  int          m_pos  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_kmer();
    logic [31:0] fwd;
    logic [31:0] rev;
    for (int j = 0; j < KL; j++) begin
      fwd[31-2*j -: 2] = hist[j];
      rev[31-2*j -: 2] = ~hist[KL-1-j];
    end
`ifdef PROJ_KMER_BUFFER_CANONICAL_EN
    return (rev < fwd) ? rev : fwd;
`else
    return fwd;
`endif
  endfunction

  task automatic model_reset();
    for (int j = 0; j < KL; j++) hist[j] = 2'b00;
    m_fill = 0;
    m_pos  = 0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [1:0] b, input logic st);
    exp_t e;
    for (int j = 0; j < KL-1; j++) hist[j] = hist[j+1];
    hist[KL-1] = b;
    if (st) begin
      m_fill = 1;
      m_pos  = 0;
    end else if (m_fill < KL) begin
      m_fill++;
    end
    if (m_fill == KL) begin
      e.kmer = model_kmer();
      e.pos  = 16'(m_pos);
      sb.push_back(e);
      m_pos = (m_pos + 1) % 65536;
    end
  endtask

  // Called just after a rising edge; leaves the base driven so streams can run back to back.
  task automatic send_base(input logic [1:0] b, input logic st);
    bit ok = 0;
    in_valid     = 1'b1;
    in_base      = b;
    in_seq_start = st;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(b, st);
      #1;
    end
  endtask

  task automatic idle(input int cycles);
    in_valid     = 1'b0;
    in_seq_start = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      emit_count++;
      last_kmer = out_kmer;
      last_pos  = out_pos;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got kmer %h pos %0d expected none", out_kmer, out_pos);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kmer", out_kmer, e.kmer);
        chk("sb_pos", 32'(out_pos), 32'(e.pos));
      end
    end
  end

  initial begin
    vec_t vecs[4];
    int   cnt0;
    logic [7:0] pat;

    vecs[0] = '{pat: 8'h55, nbases: 16, exp_kmer: 32'h55555555, exp_pos: 0, exp_cnt: 1};
    vecs[1] = '{pat: 8'h1B, nbases: 17, exp_kmer: 32'h6C6C6C6C, exp_pos: 1, exp_cnt: 2};
`ifdef PROJ_KMER_BUFFER_CANONICAL_EN
    vecs[2] = '{pat: 8'hFF, nbases: 16, exp_kmer: 32'h00000000, exp_pos: 0, exp_cnt: 1};
`else
    vecs[2] = '{pat: 8'hFF, nbases: 16, exp_kmer: 32'hFFFFFFFF, exp_pos: 0, exp_cnt: 1};
`endif
    vecs[3] = '{pat: 8'h6C, nbases: 16, exp_kmer: 32'h6C6C6C6C, exp_pos: 0, exp_cnt: 1};

    rst = 1'b1; in_valid = 1'b0; in_base = 2'b00; in_seq_start = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_kmer", out_kmer, 32'd0);
    chk("rst_out_pos", 32'(out_pos), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      cnt0 = emit_count;
      pat  = vecs[v].pat;
      for (int i = 0; i < vecs[v].nbases; i++) begin
        send_base(pat[7-2*(i%4) -: 2], i == 0);
        if (i == KL-2 || i == KL-1) begin
          in_valid = 1'b0;
          @(negedge clk);
          chk((i == KL-2) ? "fill_no_valid" : "latency_valid", 32'(out_valid), (i == KL-2) ? 32'd0 : 32'd1);
          @(posedge clk); #1;
        end
      end
      idle(3);
      chk("vec_count", 32'(emit_count - cnt0), 32'(vecs[v].exp_cnt));
      chk("vec_kmer", last_kmer, vecs[v].exp_kmer);
      chk("vec_pos", 32'(last_pos), 32'(vecs[v].exp_pos));
    end

    // Backpressure: hold the first k-mer for 5 cycles with a base waiting on the input.
    cnt0 = emit_count;
    out_ready = 1'b0;
    for (int i = 0; i < KL; i++) send_base(pat_base(8'h1B, i), i == 0);
    in_valid = 1'b1; in_base = 2'b11; in_seq_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_kmer_hold", out_kmer, 32'h1B1B1B1B);
      chk("bp_pos_hold", 32'(out_pos), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_base(2'b11, 1'b0);
    for (int i = 0; i < 3; i++) send_base(2'(i), 1'b0);
    idle(3);
    chk("bp_count", 32'(emit_count - cnt0), 32'd5);

    // New sequence on the 20th base: 15 more bases are needed before pos restarts at 0.
    for (int i = 0; i < 19; i++) send_base(2'($urandom_range(0, 3)), i == 0);
    send_base(2'b10, 1'b1);
    cnt0 = emit_count;
    for (int i = 0; i < 14; i++) send_base(2'($urandom_range(0, 3)), 1'b0);
    idle(3);
    chk("seq_no_emit", 32'(emit_count - cnt0), 32'd0);
    send_base(2'b01, 1'b0);
    idle(3);
    chk("seq_emit", 32'(emit_count - cnt0), 32'd1);
    chk("seq_pos", 32'(last_pos), 32'd0);

    // Reset while a k-mer is pending.
    out_ready = 1'b0;
    for (int i = 0; i < KL; i++) send_base(2'($urandom_range(0, 3)), i == 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pending", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cnt0 = emit_count;
    for (int i = 0; i < KL-1; i++) send_base(2'($urandom_range(0, 3)), 1'b0);
    idle(3);
    chk("rst_refill_none", 32'(emit_count - cnt0), 32'd0);
    send_base(2'b11, 1'b0);
    idle(3);
    chk("rst_refill_emit", 32'(emit_count - cnt0), 32'd1);
    chk("rst_refill_pos", 32'(last_pos), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [1:0] pat_base(input logic [7:0] p, input int i);
    return p[7-2*(i%4) -: 2];
  endfunction

endmodule
